spi_rom_responder: RTL
======================

SPI_ROM_RESPONDER -- requirements
Module: spi_rom_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the number of low-order SPI address bits used for memory addressing.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port spi_cs, input, 1 bit: chip select, active HIGH (the master's polarity).
REQ-005 SHALL have port spi_sclk, input, 1 bit: SPI clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port spi_mosi, input, 1 bit: command and address from the master, MSB first.
REQ-007 SHALL have port spi_miso, output, 1 bit: read data to the master, MSB first.
REQ-008 SHALL have port mem_addr, output, ADDR_W bits: byte address to the backing memory.
REQ-009 SHALL have port mem_rd, output, 1 bit: one-cycle read strobe.
REQ-010 SHALL have port mem_rdata, input, 8 bits: read data, valid exactly 1 clk after mem_rd.
REQ-011 SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-012 SHALL have port cmd_err, output, 1 bit: one-clk pulse when an unsupported command is received.

Function
REQ-013 SHALL pass spi_cs, spi_sclk and spi_mosi through 2-flop synchronizers, then detect SCLK rising and falling edges from the synchronized value plus one delayed copy.
REQ-014 SHALL operate correctly only if SCLK high and low phases are each at least 4 clk periods; faster SCLK is out of scope.
REQ-015 SHALL implement the states IDLE, CMD, ADDR, DATA and IGNORE.
REQ-016 SHALL, in IDLE, go to CMD with the bit counter at 0 on the first clk where synchronized CS is 1.
REQ-017 SHALL, in CMD, shift MOSI into the command register on each SCLK rise; after the 8th rise, go to ADDR if the command is 03h, else pulse cmd_err and go to IGNORE.
REQ-018 SHALL, in ADDR, shift 24 bits on SCLK rises; on the 24th rise, latch ADDR[ADDR_W-1:0], ignore the upper bits, issue mem_rd for that address, and go to DATA.
REQ-019 SHALL, in DATA, load the shift register with the prefetched byte on the first SCLK fall, drive its MSB on spi_miso, and shift out one bit per subsequent fall.
REQ-020 SHALL, on each fall that loads a byte, increment the address modulo 2^ADDR_W and issue mem_rd for the next byte into a prefetch register.
REQ-021 SHALL reload on every 8th fall, so bytes stream continuously with no gap bits.
REQ-022 SHALL update spi_miso no later than 3 clk after the physical SCLK falling edge; spi_miso SHALL be registered.
REQ-023 SHALL hold spi_miso at 0 in IDLE, CMD, ADDR and IGNORE.
REQ-024 SHALL, in IGNORE, discard all SCLK activity until CS drops.
REQ-025 SHALL, whenever synchronized CS is 0 in any state, go to IDLE on the next clk: spi_miso=0, counters cleared, no further mem_rd.
REQ-026 SHALL treat CS deasserted for 1 synchronized clk then reasserted as a new transaction starting in CMD.
REQ-027 SHALL assert mem_rd for exactly one clk per fetched byte; mem_addr SHALL hold its value between strobes.
REQ-028 SHALL treat a CS deassertion in the same clk as an SCLK edge as winning: go to IDLE, edge ignored.

Reset
REQ-029 SHALL, while reset_n=0, immediately force: state IDLE, spi_miso=0, mem_addr=0, mem_rd=0, busy=0, cmd_err=0, synchronizers cleared.
REQ-030 SHALL, if reset asserts mid-transaction, abandon that transaction; after release, stay in IDLE until CS is seen low then high again.

Verification
REQ-031 SHALL cover: memory[0x120]=A5h, [0x121]=3Ch; READ 03h with address 000120h and 16 data clocks -> MISO 1010_0101_0011_1100; mem_rd at 0x120, 0x121, 0x122.
REQ-032 SHALL cover: READ at address 7FFh (ADDR_W=11) for 2 bytes -> second byte read from 0x000, mem_addr wraps.
REQ-033 SHALL cover: command 0Bh -> cmd_err single pulse, MISO stays 0, no mem_rd, busy until CS drops.
REQ-034 SHALL cover: CS dropped after 20 data bits -> MISO=0 and busy=0 within 3 clk; next READ at 000010h returns memory[0x010] correctly.
REQ-035 SHALL cover: reset_n pulsed low mid-DATA -> outputs at reset values asynchronously; no response until a fresh CS rising edge.
REQ-036 SHALL cover: address 0xFFF120 with ADDR_W=11 -> fetch at 0x120; upper bits ignored.

Source files
------------

// File: rtl/spi_rom_responder.sv
// SPI read-only memory responder: accepts READ (03h) with a 24-bit address and streams bytes
// from a synchronous backing memory, one byte prefetched ahead of the shifter.
module spi_rom_responder #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StIgnore
  } state_e;

  logic [1:0] cs_sync_q;
  logic [1:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_dly_q;

  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sclk_dly_q  <= sclk_sync_q[1];
    end
  end

  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_dly_q;

  // After reset a transaction may only start once CS has been seen low with the
  // synchronizer already refilled, so a CS held high across reset is not a start.
  logic [1:0] warm_q;
  logic       armed_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      if (warm_q != 2'd2) begin
        warm_q <= warm_q + 2'd1;
      end
      if ((warm_q == 2'd2) && !cs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [6:0]        cmd_q;
  logic [ADDR_W-2:0] addr_sr_q;
  logic [6:0]        tx_q;
  logic [7:0]        pref_q;
  logic              rd_pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_q     <= '0;
      addr_sr_q <= '0;
      tx_q      <= '0;
      pref_q    <= '0;
      rd_pend_q <= 1'b0;
      spi_miso  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      cmd_err   <= 1'b0;
      rd_pend_q <= mem_rd;
      if (rd_pend_q) begin
        pref_q <= mem_rdata;
      end

      // CS low wins over any SCLK edge seen in the same cycle.
      if (!cs_s) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        spi_miso <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            spi_miso <= 1'b0;
            if (armed_q) begin
              state_q <= StCmd;
              cnt_q   <= '0;
            end
          end

          StCmd: begin
            if (sclk_rise) begin
              cmd_q <= 7'({cmd_q, mosi_s});
              if (cnt_q == 5'd7) begin
                cnt_q <= '0;
                if ({cmd_q, mosi_s} == 8'h03) begin
                  state_q <= StAddr;
                end else begin
                  cmd_err <= 1'b1;
                  state_q <= StIgnore;
                end
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end

          StAddr: begin
            if (sclk_rise) begin
              // Only the low ADDR_W bits are kept; upper address bits fall off the top.
              addr_sr_q <= (ADDR_W-1)'({addr_sr_q, mosi_s});
              if (cnt_q == 5'd23) begin
                mem_addr <= {addr_sr_q, mosi_s};
                mem_rd   <= 1'b1;
                cnt_q    <= '0;
                state_q  <= StData;
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end

          StData: begin
            if (sclk_fall) begin
              if (cnt_q == 5'd0) begin
                spi_miso <= pref_q[7];
                tx_q     <= pref_q[6:0];
                mem_addr <= mem_addr + 1'b1;
                mem_rd   <= 1'b1;
                cnt_q    <= 5'd1;
              end else begin
                spi_miso <= tx_q[6];
                tx_q     <= {tx_q[5:0], 1'b0};
                cnt_q    <= (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
              end
            end
          end

          StIgnore: begin
            spi_miso <= 1'b0;
          end

          default: begin
            state_q  <= StIdle;
            spi_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule
